// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: two-port register file write arbiter, p0 priority with p1 starvation relief; REG_WRITE_ARBITER_X0_FILTER_EN suppresses address-0 writes
module reg_write_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p0_valid,
    input  logic [ADDRESS_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]    p0_data,
    output logic                     p0_ready,
    input  logic                     p1_valid,
    input  logic [ADDRESS_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]    p1_data,
    output logic                     p1_ready,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0]    WD3
);
    typedef enum logic {PRIO0, FORCE1} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t state;
    logic [3:0] stall_cnt;
    logic stalled, wr_en;
    logic [ADDRESS_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;
    assign p0_ready = !rst && p0_valid && (state == PRIO0 || !p1_valid);
    assign p1_ready = !rst && p1_valid && (state == FORCE1 || !p0_valid);
    assign stalled  = p1_valid && !p1_ready;
    assign acc_addr = p0_ready ? p0_addr : p1_addr;
    assign acc_data = p0_ready ? p0_data : p1_data;
`ifdef REG_WRITE_ARBITER_X0_FILTER_EN
    assign wr_en = (p0_ready || p1_ready) && acc_addr != '0;
`else
    assign wr_en = p0_ready || p1_ready;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PRIO0;
            stall_cnt <= '0;
            WE3       <= 1'b0;
            A3        <= '0;
            WD3       <= '0;
        end else begin
            WE3 <= wr_en;
            if (wr_en) begin
                A3  <= acc_addr;
                WD3 <= acc_data;
            end
            if (state == FORCE1 || !stalled) begin
                state     <= PRIO0;
                stall_cnt <= '0;
            end else if (stall_cnt + 4'd1 == LIMIT) begin
                state     <= FORCE1;
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and randomized checks of reg_write_arbiter against a behavioural model
module tb_reg_write_arbiter;
    localparam int AW = 5, DW = 32, LIMIT = 4;
    logic clk = 1'b0, rst;
    logic p0_valid, p1_valid, p0_ready, p1_ready, WE3;
    logic [AW-1:0] p0_addr, p1_addr, A3;
    logic [DW-1:0] p0_data, p1_data, WD3;
    int checks = 0, errors = 0;
    bit m_force, m_we;
    int m_stall;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_wd;
    logic obs0, obs1;

    reg_write_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ready(p1_ready),
        .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: readiness is checked before the edge, write port after it.
    task automatic step(input logic r, input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic e0, e1;
        rst = r; p0_valid = v0; p0_addr = a0; p0_data = d0;
        p1_valid = v1; p1_addr = a1; p1_data = d1;
        #1;
        e0 = !r && v0 && (!m_force || !v1);
        e1 = !r && v1 && (m_force || !v0);
        obs0 = p0_ready; obs1 = p1_ready;
        chk("p0_ready", p0_ready, e0);
        chk("p1_ready", p1_ready, e1);
        @(posedge clk);
        if (r) begin
            m_force = 0; m_stall = 0; m_we = 0; m_a = '0; m_wd = '0;
        end else begin
            m_we = e0 || e1;
`ifdef REG_WRITE_ARBITER_X0_FILTER_EN
            if (m_we && (e0 ? a0 : a1) == '0) m_we = 0;
`endif
            if (m_we) begin
                m_a = e0 ? a0 : a1;
                m_wd = e0 ? d0 : d1;
            end
            if (m_force) begin
                m_force = 0; m_stall = 0;
            end else if (v1 && !e1) begin
                m_stall++;
                if (m_stall == LIMIT) begin m_force = 1; m_stall = 0; end
            end else m_stall = 0;
        end
        #1;
        chk("WE3", WE3, m_we);
        chk("A3", A3, m_a);
        chk("WD3", WD3, m_wd);
    endtask

    task automatic starve_seq(input string tag);
        for (int i = 0; i <= LIMIT + 1; i++) begin
            step(0, 1, AW'(i + 1), DW'(i), 1, 5'd20, 32'hAB);
            chk({tag, "_p1"}, obs1, i == LIMIT);
            chk({tag, "_p0"}, obs0, i != LIMIT);
        end
        step(0, 0, 0, 0, 1, 5'd20, 32'hAB);
    endtask

    initial begin
        bit pend0, pend1;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] rd0, rd1;
        logic rr;
        m_force = 0; m_stall = 0; m_we = 0; m_a = '0; m_wd = '0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5'd4, 32'h1, 1, 5'd6, 32'h2);
        chk("rst_we", WE3, 0); chk("rst_a3", A3, 0); chk("rst_wd", WD3, 0);
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        chk("p0_alone_rdy", obs0, 1); chk("p0_alone_we", WE3, 1);
        chk("p0_alone_a3", A3, 5); chk("p0_alone_wd", WD3, 32'hDEADBEEF);
        step(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77);
        chk("both_p0_wins", obs0, 1); chk("both_a3_first", A3, 3);
        step(0, 0, 0, 0, 1, 5'd7, 32'h77);
        chk("both_p1_next", obs1, 1); chk("both_we_second", WE3, 1); chk("both_a3_second", A3, 7);
        starve_seq("starve");
        step(0, 1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
        chk("same_first_a3", A3, 9); chk("same_first_wd", WD3, 1);
        step(0, 0, 0, 0, 1, 5'd9, 32'h2);
        chk("same_second_a3", A3, 9); chk("same_second_wd", WD3, 2);
        step(0, 1, 5'd0, 32'h55, 0, 0, 0);
        chk("x0_rdy", obs0, 1);
`ifdef REG_WRITE_ARBITER_X0_FILTER_EN
        chk("x0_we", WE3, 0); chk("x0_wd_hold", WD3, 2);
`else
        chk("x0_we", WE3, 1); chk("x0_a3", A3, 0);
`endif
        step(0, 0, 0, 0, 1, 5'd12, 32'hC);
        chk("pre_rst_we", WE3, 1); chk("pre_rst_a3", A3, 12);
        step(1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        chk("rst_rdy0", obs0, 0); chk("rst_rdy1", obs1, 0);
        chk("post_rst_we", WE3, 0); chk("post_rst_a3", A3, 0); chk("post_rst_wd", WD3, 0);
        starve_seq("starve_after_rst");
        pend0 = 0; pend1 = 0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1; ra0 = AW'($urandom); rd0 = $urandom;
            end
            if (!pend1 && $urandom_range(0, 3) != 0) begin
                pend1 = 1; ra1 = AW'($urandom); rd1 = $urandom;
            end
            rr = ($urandom_range(0, 49) == 0);
            step(rr, pend0, ra0, rd0, pend1, ra1, rd1);
            chk("one_grant", obs0 & obs1, 0);
            if (obs0) pend0 = 0;
            if (obs1) pend1 = 0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, range 1..15; consecutive p1 stall cycles before p1 is forced a grant.
REQ-004 SHALL have port clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port p0_valid  in  1  pipeline writeback request (priority requester).
REQ-007 SHALL have ports p0_addr  in  ADDRESS_WIDTH and p0_data  in  DATA_WIDTH  p0 destination register and value.
REQ-008 SHALL have port p0_ready  out  1  p0 granted this cycle.
REQ-009 SHALL have port p1_valid  in  1  multi-cycle unit writeback request.
REQ-010 SHALL have ports p1_addr  in  ADDRESS_WIDTH and p1_data  in  DATA_WIDTH  p1 destination register and value.
REQ-011 SHALL have port p1_ready  out  1  p1 granted this cycle.
REQ-012 SHALL have port WE3  out  1  register file write enable, registered.
REQ-013 SHALL have port A3  out  ADDRESS_WIDTH  register file write address, registered.
REQ-014 SHALL have port WD3  out  DATA_WIDTH  register file write data, registered.

Function
REQ-015 SHALL transfer a request when valid and ready are both 1 on a rising edge (accept); a requester holds valid, addr and data stable until accepted.
REQ-016 SHALL compute p0_ready and p1_ready combinationally from the valid inputs and the current state; at most one is 1 in any cycle.
REQ-017 SHALL implement states PRIO0 and FORCE1.
REQ-018 SHALL, in PRIO0: p0_ready = p0_valid; p1_ready = p1_valid and not p0_valid.
REQ-019 SHALL, in FORCE1: p1_ready = p1_valid; p0_ready = p0_valid and not p1_valid.
REQ-020 SHALL keep a stall counter: +1 each cycle p1_valid=1 and p1_ready=0; cleared to 0 when p1_valid=0 or p1 is accepted; never exceeds STARVE_LIMIT.
REQ-021 SHALL move PRIO0 -> FORCE1 on the edge where the counter would reach STARVE_LIMIT, clearing the counter.
REQ-022 SHALL move FORCE1 -> PRIO0 unconditionally after exactly one cycle.
REQ-023 SHALL, on the edge after an accept, drive WE3=1, A3 and WD3 equal to the accepted addr and data (latency 1 cycle); otherwise WE3=0 and A3/WD3 hold their last values.
REQ-024 SHALL treat simultaneous requests to the same address as independent: the loser stays pending and is written later, so the later write wins.
REQ-025 SHALL never produce more than one register file write per cycle.

Reset
REQ-026 SHALL, when rst=1 at a rising edge, set state PRIO0, stall counter 0, WE3=0, A3=0, WD3=0.
REQ-027 SHALL force p0_ready=0 and p1_ready=0 while rst=1; requests presented during reset are not accepted.
REQ-028 SHALL discard an accept from the cycle before reset assertion if rst=1 at the edge where WE3 would be set.

Configuration
REQ-029 SHALL use macro REG_WRITE_ARBITER_X0_FILTER_EN.
REQ-030 SHALL, with the macro defined, accept writes to address 0 normally (ready asserts) but keep WE3=0 for them; A3/WD3 hold.
REQ-031 SHALL, without the macro, forward address-0 writes with WE3=1 like any other address.

Verification
REQ-032 SHALL test: p0 alone, addr=5, data=0xDEADBEEF -> p0_ready=1 same cycle; next cycle WE3=1, A3=5, WD3=0xDEADBEEF.
REQ-033 SHALL test: p0 and p1 both valid one cycle (p0 addr=3, p1 addr=7) -> p0 wins; p1 accepted next cycle; WE3 writes 3 then 7 on consecutive cycles.
REQ-034 SHALL test: p0_valid held 1 continuously, p1_valid held 1, STARVE_LIMIT=4 -> p1 stalled 4 cycles, granted in the 5th, p0 granted again in the 6th.
REQ-035 SHALL test: both valid, same addr=9, p0 data=0x1, p1 data=0x2 -> WE3 writes 0x1 then 0x2 to address 9.
REQ-036 SHALL test: p0 write addr=0, data=0x55 -> p0_ready=1; WE3=0 next cycle with macro defined, WE3=1/A3=0 without.
REQ-037 SHALL test: accept p1 addr=12, assert rst next edge -> WE3=0, A3=0, WD3=0, state PRIO0, counter 0.
